pwm_cap: RTL
============

PWM_CAP -- requirements
Module: pwm_cap

Interface
REQ-001 Parameter cap_w, default 16, SHALL set the width of the counter and of the capture registers (range 4..31).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rstn  input  1  SHALL be the asynchronous active-low reset.
REQ-004 addr  input  5  SHALL be the register word address; decode uses addr[3:0].
REQ-005 we  input  1  SHALL be the write enable, single-cycle, qualified with addr.
REQ-006 wd  input  32  SHALL be the write data.
REQ-007 rd  output  32  SHALL be combinational read data, zero-extended.
REQ-008 irq  output  1  SHALL be the level interrupt request.
REQ-009 cap_in  input  1  SHALL be the asynchronous PWM input to be measured.

Function
REQ-010 Register map SHALL be: CR=0x0 (bit0 en, bit1 ie, bit2 pol); PER=0x4 (read-only); HI=0x8 (read-only); IR=0xC (bit0 done, bit1 ovf).
REQ-011 Unmapped read addresses SHALL return 0; writes to PER/HI or to unmapped addresses SHALL be ignored.
REQ-012 cap_in SHALL pass through a 2-flop synchronizer and one edge-detect register; pol=1 SHALL invert the synchronized input before edge detection.
REQ-013 A rising edge SHALL be declared when the synchronized input is 1 and the previous registered value is 0; a falling edge is the converse.
REQ-014 The FSM SHALL have states OFF, ARM and RUN.
REQ-015 Any state with en=0 SHALL go to OFF and clear cnt and hi_tmp; PER, HI and IR SHALL hold.
REQ-016 OFF with en=1 SHALL go to ARM.
REQ-017 ARM on a rising edge SHALL go to RUN with cnt<=0 and SHALL NOT capture.
REQ-018 RUN SHALL increment cnt by 1 per clock, saturating at all-ones.
REQ-019 In RUN, on a falling edge hi_tmp SHALL load cnt+1 (saturating).
REQ-020 In RUN, on a rising edge PER SHALL load cnt+1 (saturating), HI SHALL load hi_tmp, IR.done SHALL set, and cnt SHALL reload to 0.
REQ-021 PER and HI SHALL update in the same cycle, so they always form a coherent pair.
REQ-022 When cnt reaches all-ones in RUN, IR.ovf SHALL set and the FSM SHALL go to ARM without capturing.
REQ-023 A software write to IR SHALL load wd[1:0].
REQ-024 When a hardware set and a software write to IR occur in the same cycle, the hardware set SHALL take precedence for that bit.
REQ-025 irq SHALL equal ie AND (done OR ovf), registered-state based, with no extra latency beyond IR.
REQ-026 Capture latency SHALL be fixed: PER, HI and IR.done update on the 4th rising clk after the cap_in transition that meets setup.
REQ-027 A CR write SHALL take effect the following cycle; changing pol while en=1 MAY create one spurious edge, which software avoids.

Reset
REQ-028 On rstn low, state SHALL be OFF and all registers, the synchronizer, cnt, hi_tmp, PER, HI and IR SHALL be 0; rd SHALL be 0 at address 0x0 and irq SHALL be 0.
REQ-029 Reset assertion mid-measurement SHALL abort immediately; no partial capture SHALL become visible.

Structure
REQ-030 A package pwm_cap_pkg SHALL hold the register address constants, a packed CR struct (en, ie, pol) and the FSM state enum.
REQ-031 The existing sync module SHALL be reused for the input synchronizer.
REQ-032 The existing reg_we module SHALL be reused for the CR register; all other logic SHALL be in pwm_cap.

Verification
REQ-033 en=1, ie=1, cap_in with period 10 clk and 3 clk high -> after the 2nd rising edge, PER=10, HI=3, IR=0x1, irq=1.
REQ-034 IR.done set and software writes 0 to IR -> IR=0 and irq=0 the next cycle; a write coinciding with a capture -> done stays 1.
REQ-035 cap_w=4 and cap_in held high for 20 clk after arming -> IR.ovf=1, state ARM, PER unchanged.
REQ-036 pol=1 with period 8 and 2 clk high -> PER=8, HI=6.
REQ-037 en cleared mid-period, then re-enabled -> the first rising edge after re-enable only arms; capture occurs on the second edge.
REQ-038 rstn pulsed low mid-RUN -> all registers read 0 and irq=0 immediately, with no capture after release until two edges have been seen.

Source files
------------

// File: rtl/pwm_cap_pkg.sv
// Shared register map, control-register layout and capture FSM states for pwm_cap.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pwm_cap_pkg;

    // Register word addresses, decoded on addr[3:0]
    localparam logic [3:0] addr_cr  = 4'h0;
    localparam logic [3:0] addr_per = 4'h4;
    localparam logic [3:0] addr_hi  = 4'h8;
    localparam logic [3:0] addr_ir  = 4'hC;

    // Control register; en sits in bit 0 so the struct maps directly onto wd[2:0]
    typedef struct packed {
        logic pol;
        logic ie;
        logic en;
    } cr_t;

    typedef enum logic [1:0] {
        OFF = 2'd0,
        ARM = 2'd1,
        RUN = 2'd2
    } state_t;

endpackage

// File: rtl/reg_we.sv
// Generic register with write enable, reset to zero.
// Latency: 1 clk from we to q.
// Backpressure: none; a write is accepted whenever we is high.
module reg_we #(
    parameter int w = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         we,
    input  logic [w-1:0] d,
    output logic [w-1:0] q
);

    // Load d on a write, otherwise hold
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q <= '0;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/sync.sv
// Two-flop synchronizer for a single asynchronous level.
// Latency: 2 clk.
// Backpressure: none; samples every cycle.
module sync (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the raw input through two flops to settle metastability
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pwm_cap.sv
// PWM period / high-time capture with a small register file and level interrupt.
// Latency: PER, HI and IR.done update on the 4th clk after a qualified cap_in edge.
// Backpressure: none; reads are combinational and writes are accepted every cycle.
module pwm_cap
    import pwm_cap_pkg::*;
#(
    parameter int cap_w = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [4:0]  addr,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        irq,
    input  logic        cap_in
);

    logic [2:0]       cr_q;
    cr_t              cr;
    logic             cr_wr;
    logic             ir_wr;
    logic             cap_s;
    logic             lvl;
    logic             lvl_q;
    logic             rise_q;
    logic             fall_q;
    state_t           state;
    logic [cap_w-1:0] cnt;
    logic [cap_w-1:0] cnt_inc;
    logic             cnt_max;
    logic [cap_w-1:0] hi_tmp;
    logic [cap_w-1:0] per;
    logic [cap_w-1:0] hi;
    logic [1:0]       ir;
    logic [1:0]       ir_set;
    logic             unused_bits;

    assign cr_wr = we && (addr[3:0] == addr_cr);
    assign ir_wr = we && (addr[3:0] == addr_ir);

    reg_we #(.w(3)) u_cr (
        .clk  (clk),
        .rstn (rstn),
        .we   (cr_wr),
        .d    (wd[2:0]),
        .q    (cr_q)
    );

    assign cr = cr_t'(cr_q);

    sync u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (cap_in),
        .q    (cap_s)
    );

    // pol selects which input level counts as the "high" phase
    assign lvl = cap_s ^ cr.pol;

    // Edge detect, with the edge pulses registered so capture timing is fixed
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lvl_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            lvl_q  <= lvl;
            rise_q <= lvl & ~lvl_q;
            fall_q <= ~lvl & lvl_q;
        end
    end

    assign cnt_max = &cnt;
    assign cnt_inc = cnt_max ? cnt : cnt + {{(cap_w-1){1'b0}}, 1'b1};

    // Hardware IR events: overflow wins over a coincident capture edge
    always_comb begin
        ir_set = 2'b00;
        if (cr.en && (state == RUN)) begin
            if (cnt_max) begin
                ir_set[1] = 1'b1;
            end else if (rise_q) begin
                ir_set[0] = 1'b1;
            end
        end
    end

    // Capture FSM plus result and interrupt registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= OFF;
            cnt    <= '0;
            hi_tmp <= '0;
            per    <= '0;
            hi     <= '0;
            ir     <= 2'b00;
        end else begin
            // Software write first, then hardware sets OR over it
            ir <= (ir_wr ? wd[1:0] : ir) | ir_set;
            if (!cr.en) begin
                state  <= OFF;
                cnt    <= '0;
                hi_tmp <= '0;
            end else begin
                case (state)
                    OFF: state <= ARM;
                    ARM: begin
                        // First edge only starts the measurement
                        if (rise_q) begin
                            state <= RUN;
                            cnt   <= '0;
                        end
                    end
                    RUN: begin
                        if (cnt_max) begin
                            // Period too long to measure: drop it and re-arm
                            state <= ARM;
                        end else if (rise_q) begin
                            per <= cnt_inc;
                            hi  <= hi_tmp;
                            cnt <= '0;
                        end else begin
                            cnt <= cnt_inc;
                            if (fall_q) begin
                                hi_tmp <= cnt_inc;
                            end
                        end
                    end
                    default: state <= OFF;
                endcase
            end
        end
    end

    // Combinational register read, zero-extended; unmapped words read 0
    always_comb begin
        rd = '0;
        case (addr[3:0])
            addr_cr:  rd[2:0]       = cr_q;
            addr_per: rd[cap_w-1:0] = per;
            addr_hi:  rd[cap_w-1:0] = hi;
            addr_ir:  rd[1:0]       = ir;
            default:  rd            = '0;
        endcase
    end

    assign irq = cr.ie & (|ir);

    // addr[4] aliases and upper write-data bits have no function
    assign unused_bits = ^{addr[4], wd[31:3]};

endmodule
